// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the fetch/data memory port arbiter.
// Response FSM encoding and starvation counter sizing.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    RESP_I = 2'b01,
    RESP_D = 2'b10
  } resp_state_e;

  localparam int STARVE_LIMIT_DEF = 4;
  localparam int CNT_W            = 4;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

endpackage

// File: rtl/mem_port_arbiter_starve_counter.sv
// Saturating up-counter with clear, used to track fetch starvation.
// Clear wins over increment; the count sticks at its maximum.
module starve_counter
  import mem_port_arbiter_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  // count consecutive losing cycles, saturating at the top value
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != CNT_MAX)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates a fetch port and a load/store port onto one memory.
// Data port wins by default; a starved fetch is forced through.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_gnt,
  output logic          i_rvalid,
  output logic [DW-1:0] i_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_cnt;
  logic             starved;
  logic             i_win;
  logic             d_win;
  logic             cnt_inc;
  logic             cnt_clr;

  resp_state_e state;
  resp_state_e state_nx;

  // pick the winner; reset masks grants so the bus is quiet
  always_comb begin
    starved = i_req & (starve_cnt >= LIMIT);
    i_win   = rst & i_req & (~d_req | starved);
    d_win   = rst & d_req & ~i_win;
  end

  assign i_gnt = i_win;
  assign d_gnt = d_win;

  // steer the granted port onto the shared memory bus
  always_comb begin
    mem_en    = i_win | d_win;
    mem_we    = d_win & d_we;
    mem_addr  = '0;
    mem_wdata = '0;
    if (i_win) begin
      mem_addr = i_addr;
    end else if (d_win) begin
      mem_addr = d_addr;
    end
    if (mem_we) begin
      mem_wdata = d_wdata;
    end
  end

  assign cnt_inc = i_req & ~i_win;
  assign cnt_clr = ~cnt_inc;

  starve_counter u_starve (
    .clk (clk),
    .rst (rst),
    .inc (cnt_inc),
    .clr (cnt_clr),
    .cnt (starve_cnt)
  );

  // response state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // next response state and read-data routing
  always_comb begin
    state_nx = IDLE;
    i_rvalid = 1'b0;
    i_rdata  = '0;
    d_rvalid = 1'b0;
    d_rdata  = '0;
    unique case (1'b1)
      i_win:          state_nx = RESP_I;
      (d_win & ~d_we): state_nx = RESP_D;
      default:        state_nx = IDLE;
    endcase
    unique case (state)
      RESP_I: begin
        i_rvalid = 1'b1;
        i_rdata  = mem_rdata;
      end
      RESP_D: begin
        d_rvalid = 1'b1;
        d_rdata  = mem_rdata;
      end
      default: begin
        i_rvalid = 1'b0;
        d_rvalid = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench: vector table, directed corners, random model.
// Memory environment returns stored data or an address hash.
module tb_mem_port_arbiter;

  localparam int LIM = 4;

  logic        clk;
  logic        rst;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_gnt;
  logic        i_rvalid;
  logic [31:0] i_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int errors = 0;
  int checks = 0;

  logic [31:0] env_mem [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];

  mem_port_arbiter #(
    .AW(32), .DW(32), .STARVE_LIMIT(LIM)
  ) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt),
    .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_gnt(d_gnt),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] hashv(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'hA5A50000;
  endfunction

  function automatic logic [31:0] env_rd(input logic [31:0] a);
    if (env_mem.exists(a)) return env_mem[a];
    return hashv(a);
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return hashv(a);
  endfunction

  task automatic chk(input string nm,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 30)
        $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drv(input logic ir, input logic [31:0] ia,
                     input logic dr, input logic dwe,
                     input logic [31:0] da, input logic [31:0] dwd);
    i_req   = ir;
    i_addr  = ia;
    d_req   = dr;
    d_we    = dwe;
    d_addr  = da;
    d_wdata = dwd;
  endtask

  // memory environment: capture the access, answer next cycle
  task automatic tick();
    logic [31:0] nx;
    nx = $urandom;
    if (mem_en && mem_we) env_mem[mem_addr] = mem_wdata;
    else if (mem_en) nx = env_rd(mem_addr);
    @(posedge clk);
    #1;
    mem_rdata = nx;
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, " flags"},
        {i_gnt, d_gnt, i_rvalid, d_rvalid, mem_en, mem_we}, 0);
    chk({nm, " bus"}, {mem_addr, mem_wdata}, 0);
    chk({nm, " rdata"}, {i_rdata, d_rdata}, 0);
  endtask

  typedef struct {
    logic        ir;
    logic [31:0] ia;
    logic        dr;
    logic        dwe;
    logic [31:0] da;
    logic [31:0] dwd;
    logic        eig;
    logic        edg;
    logic        ewe;
    logic [31:0] ea;
    logic [31:0] ewd;
    int          resp;
  } vec_t;

  vec_t vt [7];

  // random-phase model state
  int          m_cnt;
  int          m_pend;
  logic [31:0] m_paddr;
  logic        hold_i;
  logic        hold_d;

  initial begin
    logic        r_ir, r_dr, r_dwe;
    logic [31:0] r_ia, r_da, r_dwd;
    logic        eg_i, eg_d, e_we;
    logic [31:0] e_addr, e_wd;
    logic        e_iv, e_dv;
    logic [31:0] e_ird, e_drd;

    env_mem[32'h10] = 32'hDEADBEEF;
    ref_mem[32'h10] = 32'hDEADBEEF;

    vt[0] = '{1, 32'h10, 0, 0, 0, 0,
              1, 0, 0, 32'h10, 0, 1};
    vt[1] = '{0, 0, 1, 1, 32'h40, 32'h12345678,
              0, 1, 1, 32'h40, 32'h12345678, 0};
    vt[2] = '{0, 0, 1, 0, 32'h80, 32'h5555,
              0, 1, 0, 32'h80, 0, 2};
    vt[3] = '{1, 32'h100, 1, 0, 32'h84, 32'h77,
              0, 1, 0, 32'h84, 0, 2};
    vt[4] = '{1, 32'h104, 1, 1, 32'h44, 32'hAABBCCDD,
              0, 1, 1, 32'h44, 32'hAABBCCDD, 0};
    vt[5] = '{0, 32'h55, 0, 1, 32'h66, 32'h99,
              0, 0, 0, 0, 0, 0};
    vt[6] = '{1, 32'h108, 0, 1, 32'h6C, 32'hFFFF,
              1, 0, 0, 32'h108, 0, 1};

    // reset with both ports requesting
    rst = 1'b0;
    mem_rdata = 32'hCAFEF00D;
    drv(1, 32'h10, 1, 0, 32'h88, 32'h1);
    @(negedge clk);
    chk_all_zero("reset");
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("first grant", {i_gnt, d_gnt, mem_addr}, {2'b01, 32'h88});
    tick();
    drv(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("first resp", {d_rvalid, d_rdata, i_rvalid},
        {1'b1, ref_rd(32'h88), 1'b0});
    tick();

    // single-cycle vector table, idle cycle after each
    foreach (vt[k]) begin
      drv(vt[k].ir, vt[k].ia, vt[k].dr,
          vt[k].dwe, vt[k].da, vt[k].dwd);
      @(negedge clk);
      chk($sformatf("vec%0d grant", k),
          {i_gnt, d_gnt, mem_en},
          {vt[k].eig, vt[k].edg, vt[k].eig | vt[k].edg});
      chk($sformatf("vec%0d bus", k),
          {mem_we, mem_addr, mem_wdata},
          {vt[k].ewe, vt[k].ea, vt[k].ewd});
      tick();
      drv(0, 0, 0, 0, 0, 0);
      @(negedge clk);
      chk($sformatf("vec%0d resp", k),
          {i_rvalid, i_rdata, d_rvalid, d_rdata},
          {vt[k].resp == 1,
           (vt[k].resp == 1) ? ref_rd(vt[k].ia) : 32'h0,
           vt[k].resp == 2,
           (vt[k].resp == 2) ? ref_rd(vt[k].da) : 32'h0});
      tick();
    end

    // contention: data wins LIM cycles, then fetch once
    drv(1, 32'h300, 1, 0, 32'h304, 0);
    for (int c = 0; c < 15; c++) begin
      logic ei;
      ei = ((c % (LIM + 1)) == LIM);
      @(negedge clk);
      chk($sformatf("contend%0d", c), {i_gnt, d_gnt}, {ei, ~ei});
      if (c > 0) begin
        logic pi;
        pi = (((c - 1) % (LIM + 1)) == LIM);
        chk($sformatf("contend%0d resp", c),
            {i_rvalid, d_rvalid, i_rdata | d_rdata},
            {pi, ~pi, pi ? ref_rd(32'h300) : ref_rd(32'h304)});
      end
      tick();
    end
    drv(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    tick();

    // back-to-back load then fetch
    drv(0, 0, 1, 0, 32'h308, 0);
    @(negedge clk);
    chk("b2b load gnt", {i_gnt, d_gnt}, 2'b01);
    tick();
    drv(1, 32'h30C, 0, 0, 0, 0);
    @(negedge clk);
    chk("b2b fetch gnt", {i_gnt, d_gnt}, 2'b10);
    chk("b2b d resp", {d_rvalid, d_rdata, i_rvalid},
        {1'b1, ref_rd(32'h308), 1'b0});
    tick();
    drv(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("b2b i resp", {i_rvalid, i_rdata, d_rvalid},
        {1'b1, ref_rd(32'h30C), 1'b0});
    tick();

    // reset lands while a fetch response is pending
    drv(1, 32'h20, 0, 0, 0, 0);
    @(negedge clk);
    chk("rstmid gnt", i_gnt, 1'b1);
    #1;
    rst = 1'b0;
    #1;
    chk_all_zero("rstmid async");
    tick();
    @(negedge clk);
    chk_all_zero("rstmid held");
    @(posedge clk);
    #1;
    drv(0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("rstmid no rvalid", {i_rvalid, d_rvalid, i_rdata}, 0);
    tick();

    // random stress against the behavioural model
    m_cnt  = 0;
    m_pend = 0;
    m_paddr = 0;
    hold_i = 1'b0;
    hold_d = 1'b0;
    r_ir = 0; r_ia = 0; r_dr = 0;
    r_dwe = 0; r_da = 0; r_dwd = 0;
    for (int n = 0; n < 10000; n++) begin
      if (!hold_i) begin
        r_ir = ($urandom_range(0, 9) < 6);
        r_ia = 32'h200 + (32'($urandom_range(0, 15)) << 2);
      end
      if (!hold_d) begin
        r_dr  = ($urandom_range(0, 9) < 6);
        r_dwe = $urandom_range(0, 1);
        r_da  = 32'h200 + (32'($urandom_range(0, 15)) << 2);
        r_dwd = $urandom;
      end
      drv(r_ir, r_ia, r_dr, r_dwe, r_da, r_dwd);

      eg_i = r_ir && (!r_dr || m_cnt >= LIM);
      eg_d = r_dr && !eg_i;
      e_we = eg_d && r_dwe;
      e_addr = eg_i ? r_ia : (eg_d ? r_da : 32'h0);
      e_wd = e_we ? r_dwd : 32'h0;
      e_iv = (m_pend == 1);
      e_dv = (m_pend == 2);
      e_ird = e_iv ? ref_rd(m_paddr) : 32'h0;
      e_drd = e_dv ? ref_rd(m_paddr) : 32'h0;

      @(negedge clk);
      chk("rnd excl", i_gnt & d_gnt, 1'b0);
      chk("rnd grant", {i_gnt, d_gnt}, {eg_i, eg_d});
      chk("rnd bus", {mem_en, mem_we, mem_addr, mem_wdata},
          {eg_i | eg_d, e_we, e_addr, e_wd});
      chk("rnd resp", {i_rvalid, i_rdata, d_rvalid, d_rdata},
          {e_iv, e_ird, e_dv, e_drd});

      if (e_we) ref_mem[r_da] = r_dwd;
      m_pend  = eg_i ? 1 : ((eg_d && !r_dwe) ? 2 : 0);
      m_paddr = e_addr;
      if (!r_ir || eg_i) m_cnt = 0;
      else if (m_cnt < 15) m_cnt = m_cnt + 1;
      hold_i = r_ir && !eg_i;
      hold_d = r_dr && !eg_d;
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
